// File: rtl/friscv_memfy_or_tracker.sv
// ----------------------------------------------------------------------------
// friscv_memfy_or_tracker
//
// Tracks the outstanding AXI read and write requests of the memfy load/store
// unit. Each direction keeps an in-order ring of cache-block addresses. The
// collision flags let memfy hold back a request that would overtake a pending
// access of the other direction.
//
// Ports
//   aclk, aresetn, srst      clock, async active-low reset, sync active-high reset
//   req_valid/ready/wr/addr  memfy request handshake, direction and byte address
//   bvalid, bready           write response handshake (frees the oldest write)
//   rvalid, rready, rlast    read data handshake (last beat frees the oldest read)
//   wr_coll, rd_coll         a pending write/read conflicts with req_addr
//   wr_full, rd_full         table holds MAX_OR entries (registered)
//   pending_wr, pending_rd   an entry remains that is not being released now
//   wr_or_cnt, rd_or_cnt     entry counts (registered)
//   err_ovf, err_udf         sticky push-dropped / release-while-empty flags
// ----------------------------------------------------------------------------

// One direction's ring of outstanding block addresses.
module friscv_memfy_or_table #(
  parameter int MAX_OR = 8,
  parameter int BLK_W  = 28,
  parameter int CNT_W  = $clog2(MAX_OR + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             push,
  input  logic             pull,
  input  logic [BLK_W-1:0] req_blk,
  output logic             pending,
  output logic             hit,
  output logic             full,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_evt,
  output logic             udf_evt
);
  localparam int PTR_W = $clog2(MAX_OR);

  logic [MAX_OR-1:0] valid;
  logic [MAX_OR-1:0] eff;
  logic [BLK_W-1:0]  blk_mem [MAX_OR];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              empty;
  logic              at_max;
  logic              do_push;
  logic              do_pull;

  assign empty   = (cnt == '0);
  assign at_max  = (cnt == CNT_W'(MAX_OR));
  // A pull on an empty ring is ignored; a full ring accepts a push only when
  // the tail is released in the same cycle (the freed slot is the head slot).
  assign do_pull = pull & ~empty;
  assign do_push = push & (~at_max | pull);
  assign ovf_evt = push & at_max & ~pull;
  assign udf_evt = pull & empty;

  // The tail entry being released this cycle no longer counts as pending.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    eff = valid;
    if (pull) eff[tail] = 1'b0;
  end

  assign pending = |eff;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_OR; i++) begin
      if (eff[i] && (blk_mem[i] == req_blk)) hit = 1'b1;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OR - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state uses non-blocking assignments; when head==tail (full ring with
  // push and pull) the later valid[head] write wins, leaving the slot valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
    end else if (srst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
    end else begin
      if (do_pull) begin
        valid[tail] <= 1'b0;
        tail        <= ptr_inc(tail);
      end
      if (do_push) begin
        valid[head] <= 1'b1;
        head        <= ptr_inc(head);
      end
      case ({do_push, do_pull})
        2'b10: begin
          cnt  <= cnt + 1'b1;
          full <= (cnt == CNT_W'(MAX_OR - 1));
        end
        2'b01: begin
          cnt  <= cnt - 1'b1;
          full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the address storage has no reset; valid bits alone qualify its contents.
  always_ff @(posedge aclk) begin
    if (do_push) blk_mem[head] <= req_blk;
  end
endmodule

module friscv_memfy_or_tracker #(
  parameter int AXI_ORDERING = 1,
  parameter int MAX_OR       = 8,
  parameter int AXI_ADDR_W   = 32,
  parameter int MEM_BLOCK_W  = 128
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         srst,
  input  logic                         req_valid,
  input  logic                         req_ready,
  input  logic                         req_wr,
  input  logic [AXI_ADDR_W-1:0]        req_addr,
  input  logic                         bvalid,
  input  logic                         bready,
  input  logic                         rvalid,
  input  logic                         rready,
  input  logic                         rlast,
  output logic                         wr_coll,
  output logic                         rd_coll,
  output logic                         wr_full,
  output logic                         rd_full,
  output logic                         pending_wr,
  output logic                         pending_rd,
  output logic [$clog2(MAX_OR+1)-1:0]  wr_or_cnt,
  output logic [$clog2(MAX_OR+1)-1:0]  rd_or_cnt,
  output logic                         err_ovf,
  output logic                         err_udf
);
  localparam int ADDR_LSB = $clog2(MEM_BLOCK_W / 8);
  localparam int BLK_W    = AXI_ADDR_W - ADDR_LSB;

  logic [BLK_W-1:0] req_blk;
  logic push_wr, push_rd, pull_wr, pull_rd;
  logic wr_hit, rd_hit;
  logic wr_ovf, rd_ovf, wr_udf, rd_udf;

  assign req_blk = req_addr[AXI_ADDR_W-1:ADDR_LSB];
  assign push_wr = req_valid & req_ready & req_wr;
  assign push_rd = req_valid & req_ready & ~req_wr;
  assign pull_wr = bvalid & bready;
  assign pull_rd = rvalid & rready & rlast;

  friscv_memfy_or_table #(.MAX_OR(MAX_OR), .BLK_W(BLK_W)) u_wr_table (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .push    (push_wr),
    .pull    (pull_wr),
    .req_blk (req_blk),
    .pending (pending_wr),
    .hit     (wr_hit),
    .full    (wr_full),
    .cnt     (wr_or_cnt),
    .ovf_evt (wr_ovf),
    .udf_evt (wr_udf)
  );

  friscv_memfy_or_table #(.MAX_OR(MAX_OR), .BLK_W(BLK_W)) u_rd_table (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .push    (push_rd),
    .pull    (pull_rd),
    .req_blk (req_blk),
    .pending (pending_rd),
    .hit     (rd_hit),
    .full    (rd_full),
    .cnt     (rd_or_cnt),
    .ovf_evt (rd_ovf),
    .udf_evt (rd_udf)
  );

  // Ordering policy: strict blocks on anything pending, block mode only on the
  // same cache block, relaxed never blocks.
  generate
    if (AXI_ORDERING == 0) begin : g_strict
      assign wr_coll = pending_wr;
      assign rd_coll = pending_rd;
    end else if (AXI_ORDERING == 1) begin : g_block
      assign wr_coll = wr_hit;
      assign rd_coll = rd_hit;
    end else begin : g_relaxed
      assign wr_coll = 1'b0;
      assign rd_coll = 1'b0;
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (srst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | wr_ovf | rd_ovf;
      err_udf <= err_udf | wr_udf | rd_udf;
    end
  end
endmodule

// File: tb/tb_friscv_memfy_or_tracker.sv
// ----------------------------------------------------------------------------
// Bench for friscv_memfy_or_tracker. Three instances share one stimulus:
//   dut 0: block ordering, MAX_OR=8
//   dut 1: strict ordering, MAX_OR=5
//   dut 2: relaxed ordering, MAX_OR=5
// A queue-based reference model predicts every output of every instance on
// every cycle; a table of directed rows and a few hand sequences add explicit
// expectations for dut 0 and dut 1.
// ----------------------------------------------------------------------------
module tb_friscv_memfy_or_tracker;
  localparam int NI = 3;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn, srst, req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic        bvalid, bready, rvalid, rready, rlast;

  logic wr_coll [NI], rd_coll [NI], wr_full [NI], rd_full [NI];
  logic pending_wr [NI], pending_rd [NI], err_ovf [NI], err_udf [NI];
  logic [3:0] w_cnt0, r_cnt0;
  logic [2:0] w_cnt1, r_cnt1, w_cnt2, r_cnt2;

  friscv_memfy_or_tracker #(.AXI_ORDERING(1), .MAX_OR(8)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .bvalid(bvalid), .bready(bready), .rvalid(rvalid),
    .rready(rready), .rlast(rlast), .wr_coll(wr_coll[0]), .rd_coll(rd_coll[0]),
    .wr_full(wr_full[0]), .rd_full(rd_full[0]), .pending_wr(pending_wr[0]),
    .pending_rd(pending_rd[0]), .wr_or_cnt(w_cnt0), .rd_or_cnt(r_cnt0),
    .err_ovf(err_ovf[0]), .err_udf(err_udf[0]));

  friscv_memfy_or_tracker #(.AXI_ORDERING(0), .MAX_OR(5)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .bvalid(bvalid), .bready(bready), .rvalid(rvalid),
    .rready(rready), .rlast(rlast), .wr_coll(wr_coll[1]), .rd_coll(rd_coll[1]),
    .wr_full(wr_full[1]), .rd_full(rd_full[1]), .pending_wr(pending_wr[1]),
    .pending_rd(pending_rd[1]), .wr_or_cnt(w_cnt1), .rd_or_cnt(r_cnt1),
    .err_ovf(err_ovf[1]), .err_udf(err_udf[1]));

  friscv_memfy_or_tracker #(.AXI_ORDERING(2), .MAX_OR(5)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .bvalid(bvalid), .bready(bready), .rvalid(rvalid),
    .rready(rready), .rlast(rlast), .wr_coll(wr_coll[2]), .rd_coll(rd_coll[2]),
    .wr_full(wr_full[2]), .rd_full(rd_full[2]), .pending_wr(pending_wr[2]),
    .pending_rd(pending_rd[2]), .wr_or_cnt(w_cnt2), .rd_or_cnt(r_cnt2),
    .err_ovf(err_ovf[2]), .err_udf(err_udf[2]));

  typedef struct packed {
    logic       wr_coll, rd_coll, wr_full, rd_full, pending_wr, pending_rd;
    logic [3:0] wr_cnt, rd_cnt;
    logic       ovf, udf;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic obs_t dut_obs(input int k);
    obs_t o;
    o.wr_coll    = wr_coll[k];
    o.rd_coll    = rd_coll[k];
    o.wr_full    = wr_full[k];
    o.rd_full    = rd_full[k];
    o.pending_wr = pending_wr[k];
    o.pending_rd = pending_rd[k];
    o.ovf        = err_ovf[k];
    o.udf        = err_udf[k];
    case (k)
      0:       begin o.wr_cnt = w_cnt0;        o.rd_cnt = r_cnt0;        end
      1:       begin o.wr_cnt = {1'b0, w_cnt1}; o.rd_cnt = {1'b0, r_cnt1}; end
      default: begin o.wr_cnt = {1'b0, w_cnt2}; o.rd_cnt = {1'b0, r_cnt2}; end
    endcase
    return o;
  endfunction

  // ---------------- reference model: per-direction queues of block numbers
  typedef logic [27:0] blk_t;
  blk_t q [2*NI][$];          // index 2*k = writes of instance k, 2*k+1 = reads
  bit   m_ovf [NI];
  bit   m_udf [NI];

  function automatic int max_of(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic int ord_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
  endfunction

  function automatic obs_t model_out(input int k);
    obs_t o;
    blk_t b;
    bit   pl [2];
    bit   pend [2];
    bit   hit [2];
    bit   coll [2];
    int   idx;
    o = '0;
    b = req_addr[31:4];
    pl[0] = bvalid & bready;
    pl[1] = rvalid & rready & rlast;
    for (int d = 0; d < 2; d++) begin
      idx = 2 * k + d;
      pend[d] = 1'b0;
      hit[d]  = 1'b0;
      for (int i = 0; i < q[idx].size(); i++) begin
        if (i == 0 && pl[d]) continue;   // oldest entry is leaving this cycle
        pend[d] = 1'b1;
        if (q[idx][i] == b) hit[d] = 1'b1;
      end
      case (ord_of(k))
        0:       coll[d] = pend[d];
        1:       coll[d] = hit[d];
        default: coll[d] = 1'b0;
      endcase
    end
    o.wr_coll    = coll[0];
    o.rd_coll    = coll[1];
    o.pending_wr = pend[0];
    o.pending_rd = pend[1];
    o.wr_full    = (q[2*k].size() == max_of(k));
    o.rd_full    = (q[2*k+1].size() == max_of(k));
    o.wr_cnt     = 4'(q[2*k].size());
    o.rd_cnt     = 4'(q[2*k+1].size());
    o.ovf        = m_ovf[k];
    o.udf        = m_udf[k];
    return o;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      q[2*k].delete();
      q[2*k+1].delete();
      m_ovf[k] = 1'b0;
      m_udf[k] = 1'b0;
    end
  endtask

  // Applies the clock edge's effect using the inputs held across the edge.
  task automatic model_tick();
    bit   ps [2];
    bit   pl [2];
    blk_t b;
    int   idx;
    int   n;
    if (srst) begin
      model_clear();
    end else begin
      b = req_addr[31:4];
      ps[0] = req_valid & req_ready & req_wr;
      ps[1] = req_valid & req_ready & ~req_wr;
      pl[0] = bvalid & bready;
      pl[1] = rvalid & rready & rlast;
      for (int k = 0; k < NI; k++) begin
        for (int d = 0; d < 2; d++) begin
          idx = 2 * k + d;
          n   = q[idx].size();
          if (pl[d] && n == 0) begin
            m_udf[k] = 1'b1;
            if (ps[d]) q[idx].push_back(b);
          end else if (ps[d] && !pl[d] && n == max_of(k)) begin
            m_ovf[k] = 1'b1;
          end else begin
            if (pl[d]) void'(q[idx].pop_front());
            if (ps[d]) q[idx].push_back(b);
          end
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (inputs change on the falling edge)
  task automatic drive(input bit s, input bit rqv, input bit rqr, input bit wr,
                       input logic [31:0] a, input bit bv, input bit br,
                       input bit rv, input bit rr, input bit rl);
    srst = s; req_valid = rqv; req_ready = rqr; req_wr = wr; req_addr = a;
    bvalid = bv; bready = br; rvalid = rv; rready = rr; rlast = rl;
  endtask

  task automatic sample(input string tag);
    #2;
    for (int k = 0; k < NI; k++)
      check($sformatf("%s model[%0d]", tag, k), 32'(dut_obs(k)), 32'(model_out(k)));
  endtask

  task automatic tick();
    @(posedge aclk);
    model_tick();
    @(negedge aclk);
  endtask

  // ---------------- directed table for dut 0 (block mode, MAX_OR=8)
  typedef struct {
    bit          srst, rqv, rqr, wr;
    logic [31:0] addr;
    bit          bv, br, rv, rr, rl;
    obs_t        exp;
  } row_t;

  row_t tbl [$];

  function automatic row_t r(input bit s, input bit rqv, input bit rqr, input bit wr,
                             input logic [31:0] a, input bit bv, input bit br, input bit rv,
                             input bit rr, input bit rl, input bit wc, input bit rc,
                             input bit pw, input bit pr, input int wcnt, input int rcnt,
                             input bit ovf, input bit udf);
    row_t x;
    x.srst = s; x.rqv = rqv; x.rqr = rqr; x.wr = wr; x.addr = a;
    x.bv = bv; x.br = br; x.rv = rv; x.rr = rr; x.rl = rl;
    x.exp = '{wr_coll: wc, rd_coll: rc, wr_full: 1'b0, rd_full: 1'b0, pending_wr: pw,
              pending_rd: pr, wr_cnt: 4'(wcnt), rd_cnt: 4'(rcnt), ovf: ovf, udf: udf};
    return x;
  endfunction

  initial begin
    // Expected outputs are sampled before the edge that consumes the row's inputs.
    //          s rv ry wr addr      bv br rv rr rl   wc rc pw pr wn rn ov ud
    tbl.push_back(r(0, 0, 0, 0, 32'h0000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(0, 1, 1, 1, 32'h1000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h100C, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h1010, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(r(0, 1, 1, 0, 32'h2000, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h2004, 0, 0, 0, 0, 0,  0, 1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h1000, 1, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h2000, 0, 0, 1, 1, 0,  0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h2000, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h0000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h0000, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 0, 32'h0000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 1, 1, 1, 32'h3000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 1, 1, 1, 32'h3010, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(r(0, 1, 1, 1, 32'h3020, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2, 0, 0, 1));
    tbl.push_back(r(1, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0,  1, 0, 1, 0, 3, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    aresetn = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (3) @(negedge aclk);
    #2;
    for (int k = 0; k < NI; k++) check($sformatf("reset dut%0d", k), 32'(dut_obs(k)), 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;

    // ---- directed table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].srst, tbl[i].rqv, tbl[i].rqr, tbl[i].wr, tbl[i].addr,
            tbl[i].bv, tbl[i].br, tbl[i].rv, tbl[i].rr, tbl[i].rl);
      sample($sformatf("table[%0d]", i));
      check($sformatf("table[%0d] dut0", i), 32'(dut_obs(0)), 32'(tbl[i].exp));
      tick();
    end

    // ---- fill and overflow of the read table (dut 0 holds 8)
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 0, 32'h5000 + 32'(16 * i), 0, 0, 0, 0, 0);
      sample("fill");
      tick();
    end
    drive(0, 0, 0, 0, 32'h5000, 0, 0, 0, 0, 0);
    sample("full");
    check("full rd_full", 32'(rd_full[0]), 32'd1);
    check("full rd_or_cnt", 32'(r_cnt0), 32'd8);
    check("full err_ovf", 32'(err_ovf[0]), 32'd0);
    tick();
    drive(0, 1, 1, 0, 32'h5080, 0, 0, 1, 1, 1);   // push while releasing the tail
    sample("full push+pull");
    tick();
    drive(0, 0, 0, 0, 32'h5080, 0, 0, 0, 0, 0);
    sample("after push+pull");
    check("push+pull rd_or_cnt", 32'(r_cnt0), 32'd8);
    check("push+pull err_ovf", 32'(err_ovf[0]), 32'd0);
    check("push+pull rd_coll", 32'(rd_coll[0]), 32'd1);
    tick();
    drive(0, 1, 1, 0, 32'h5090, 0, 0, 1, 1, 0);   // beat without rlast frees nothing
    sample("overflow push");
    tick();
    drive(0, 0, 0, 0, 32'h5090, 0, 0, 0, 0, 0);
    sample("after overflow");
    check("overflow err_ovf", 32'(err_ovf[0]), 32'd1);
    check("overflow rd_or_cnt", 32'(r_cnt0), 32'd8);
    check("overflow rd_coll", 32'(rd_coll[0]), 32'd0);

    // ---- asynchronous reset in the middle of a burst
    drive(0, 1, 1, 1, 32'h7000, 1, 1, 1, 1, 1);
    #2;
    aresetn = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) check($sformatf("async reset dut%0d", k), 32'(dut_obs(k)), 32'h0);
    model_clear();
    @(negedge aclk);
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    aresetn = 1'b1;

    // ---- wrap-around on the MAX_OR=5 instances: 12 push/pull pairs
    drive(0, 1, 1, 1, 32'h6000, 0, 0, 0, 0, 0); sample("wrap pre0"); tick();
    drive(0, 1, 1, 1, 32'h6010, 0, 0, 0, 0, 0); sample("wrap pre1"); tick();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 1, 1, 32'h6000 + 32'(16 * (i + 2)), 1, 1, 0, 0, 0);
      sample($sformatf("wrap pair%0d", i));
      tick();
      if (i % 2 == 1) begin
        drive(0, 0, 0, 0, 32'h6000 + 32'(16 * (i + 2)), 0, 0, 0, 0, 0);
        sample($sformatf("wrap query%0d", i));
        check($sformatf("wrap query%0d dut0 wr_coll", i), 32'(wr_coll[0]), 32'd1);
        tick();
      end
    end
    drive(0, 0, 0, 0, 32'h6000, 1, 1, 0, 0, 0); sample("wrap drain0"); tick();
    drive(0, 0, 0, 0, 32'h6000, 1, 1, 0, 0, 0); sample("wrap drain1"); tick();
    drive(0, 0, 0, 0, 32'h6000, 0, 0, 0, 0, 0);
    sample("wrap end");
    check("wrap err_ovf", 32'(err_ovf[1]), 32'd0);
    check("wrap err_udf", 32'(err_udf[1]), 32'd0);
    check("wrap wr_or_cnt", 32'(w_cnt1), 32'd0);
    tick();

    // ---- randomized traffic over a small set of blocks
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1,
            32'h4000 + 32'($urandom_range(0, 5) * 16) + 32'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      sample($sformatf("rand%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
